data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for the core's load/store port: multi-cycle data memory with valid/ready handshake.
//  Accepts one request (address, funct3 size code, write data), waits LATENCY cycles, then returns a response.
//  A load returns sign- or zero-extended read data; a store returns an acknowledge.
//  Sits between the core's load/store path and the data storage; replaces the zero-latency Data_Memory in the multicycle core.
// PARAMETERS
//  DEPTH    64  number of 64-bit doubleword entries; byte-addressed span is DEPTH*8 bytes
//  LATENCY  2   cycles spent in BUSY between accept and response; legal range 1..15
// PORTS
//  clk        in   1   single clock; all state updates on rising edge
//  reset      in   1   synchronous, active-high reset
//  req_valid  in   1   request present
//  req_ready  out  1   responder can accept; high only in IDLE
//  req_write  in   1   1=store, 0=load
//  req_addr   in   64  byte address
//  req_funct3 in   3   RISC-V funct3 size/sign code
//  req_wdata  in   64  store data, right-aligned
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   requester takes the response
//  rsp_rdata  out  64  load result, extended; 0 for stores and errors
//  rsp_err    out  1   misaligned or out-of-range access
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1 from the first cycle after reset; rsp_valid=0; rsp_rdata=0; rsp_err=0; all DEPTH entries cleared to 0.
//  FSM:
//   - IDLE -> BUSY on req_valid&req_ready; write, addr, funct3 and wdata are captured; counter loaded with LATENCY-1.
//   - BUSY: counter decrements each cycle. At counter==0 -> RESP. On that same edge the store commits or the load data is registered.
//   - RESP: rsp_valid=1 and outputs held stable until rsp_valid&rsp_ready; -> IDLE on that edge.
//  Latency: an accept at edge N gives rsp_valid=1 after edge N+LATENCY. One request in flight; req_ready=0 in BUSY/RESP.
//  Back-to-back: a new accept is possible in the cycle after the RESP handshake (no IDLE bypass).
//  Index: addr[3+log2(DEPTH)-1:3]. Byte lane: addr[2:0].
//  Size: funct3[1:0] 00=B, 01=H, 10=W, 11=D.
//  Sign: for loads, funct3[2]=1 zero-extends; funct3[2]=0 sign-extends.
//  Illegal: funct3=111 is illegal -> rsp_err. Store with funct3[2]=1 -> rsp_err.
//  Misaligned: addr not a multiple of the access size -> rsp_err=1, rdata=0, no memory change.
//  Out of range: addr >= DEPTH*8 -> rsp_err=1, rdata=0, no memory change.
//  Stores: only the addressed bytes are updated; the other bytes of the doubleword are preserved.
//   Data is taken from the low bytes of wdata, shifted to the lane.
//  rsp_rdata is 0 for stores and for any error.
//  Reset asserted mid-operation (BUSY or RESP): transaction aborted; an uncommitted store is dropped; outputs return to reset values.
//  rsp_ready ignored outside RESP; req_* ignored outside IDLE.
// STRUCTURE
//  data_mem_pkg:
//   - state encoding IDLE/BUSY/RESP
//   - funct3 constants LB,LH,LW,LD,LBU,LHU,LWU,SB,SH,SW,SD
//   - size decode function
//  Sub-module mem_lane_align (combinational):
//   - load path: extracts the lane from the doubleword and sign/zero-extends it
//   - store path: builds the merged doubleword from old data, wdata, lane and size
//   - flags misalignment
//  Top level: FSM, latency counter, captured request registers, storage array, response registers.
// TESTING
//  1 Reset, then LD addr 0x10 -> rsp_valid exactly LATENCY cycles after accept; rdata=0; err=0.
//  2 SD 0x8 wdata=0x8877665544332211, then LB 0x8 -> 0x0000000000000011; LB 0xF -> 0xFFFFFFFFFFFFFF88; LBU 0xF -> 0x88.
//  3 SH 0xA wdata=0xBEEF over stored 0x8877665544332211, then LD 0x8 -> 0x88776655BEEF2211; LHU 0xA -> 0xBEEF.
//  4 LW 0x6 (misaligned) -> err=1, rdata=0. SD 0x200 with DEPTH=64 -> err=1, and a following LD of every entry shows no change.
//  5 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable and req_ready=0; next accept only after the handshake.
//  6 Assert reset during BUSY of SD 0x0 wdata=0xFFFF... -> next cycle rsp_valid=0, req_ready=1; LD 0x0 returns 0.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types, funct3 codes and size helpers for the multi-cycle data memory responder.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W,
        SZ_D
    } size_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

    localparam logic [2:0] F3_ILLEGAL = 3'b111;

    function automatic size_t decode_size(input logic [2:0] funct3);
        return size_t'(funct3[1:0]);
    endfunction

    // Byte-enable pattern of an access at lane 0.
    function automatic logic [7:0] size_mask(input size_t size);
        logic [7:0] mask;
        mask = 8'hFF;
        case (size)
            SZ_B:    mask = 8'h01;
            SZ_H:    mask = 8'h03;
            SZ_W:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: load extract/extend, store byte merge, alignment and encoding checks.
module mem_lane_align
    import data_mem_pkg::*;
(
    input  logic [63:0] old_data,
    input  logic [63:0] wdata,
    input  logic [2:0]  lane,
    input  logic [2:0]  funct3,
    input  logic        write,
    output logic [63:0] load_data,
    output logic [63:0] store_data,
    output logic        misaligned,
    output logic        illegal
);

    size_t       size;
    logic [63:0] shifted_old;
    logic [63:0] shifted_wdata;
    logic [7:0]  lane_mask;

    always_comb begin
        // NOTE: every output and temporary gets a default first, so no path can leave one unassigned and infer a latch.
        load_data     = '0;
        store_data    = old_data;
        misaligned    = 1'b0;
        size          = decode_size(funct3);
        shifted_old   = old_data >> {lane, 3'b000};
        shifted_wdata = wdata << {lane, 3'b000};
        lane_mask     = size_mask(size) << lane;

        // funct3[2] selects zero extension; funct3=111 is caught by the illegal flag.
        case (size)
            SZ_B: load_data = funct3[2] ? {56'd0, shifted_old[7:0]}
                                        : {{56{shifted_old[7]}}, shifted_old[7:0]};
            SZ_H: load_data = funct3[2] ? {48'd0, shifted_old[15:0]}
                                        : {{48{shifted_old[15]}}, shifted_old[15:0]};
            SZ_W: load_data = funct3[2] ? {32'd0, shifted_old[31:0]}
                                        : {{32{shifted_old[31]}}, shifted_old[31:0]};
            default: load_data = shifted_old;
        endcase

        for (int i = 0; i < 8; i++) begin
            if (lane_mask[i]) begin
                store_data[8*i +: 8] = shifted_wdata[8*i +: 8];
            end
        end

        case (size)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = lane[0];
            SZ_W:    misaligned = |lane[1:0];
            default: misaligned = |lane;
        endcase
    end

    assign illegal = (funct3 == F3_ILLEGAL) || (write && funct3[2]);

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory with valid/ready request and response channels for the core's load/store port.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'd8;

    state_t      state;
    logic [3:0]  cnt;
    logic        cap_write;
    logic [63:0] cap_addr;
    logic [2:0]  cap_funct3;
    logic [63:0] cap_wdata;

    logic [63:0] mem [DEPTH];

    logic [IDX_W-1:0] idx;
    logic [63:0]      old_data;
    logic [63:0]      load_data;
    logic [63:0]      store_data;
    logic             misaligned;
    logic             illegal;
    logic             out_of_range;
    logic             access_err;

    assign idx          = cap_addr[3 +: IDX_W];
    assign old_data     = mem[idx];
    assign out_of_range = cap_addr >= SPAN;
    assign access_err   = misaligned || illegal || out_of_range;

    mem_lane_align u_align (
        .old_data   (old_data),
        .wdata      (cap_wdata),
        .lane       (cap_addr[2:0]),
        .funct3     (cap_funct3),
        .write      (cap_write),
        .load_data  (load_data),
        .store_data (store_data),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    // NOTE: all state below uses <= so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            cnt        <= '0;
            cap_write  <= 1'b0;
            cap_addr   <= '0;
            cap_funct3 <= '0;
            cap_wdata  <= '0;
            // NOTE: the storage is deliberately cleared on reset because the core relies on a zeroed data memory; this rules out a plain RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        state      <= BUSY;
                        req_ready  <= 1'b0;
                        cnt        <= 4'(LATENCY - 1);
                        cap_write  <= req_write;
                        cap_addr   <= req_addr;
                        cap_funct3 <= req_funct3;
                        cap_wdata  <= req_wdata;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= access_err;
                        rsp_rdata <= (access_err || cap_write) ? '0 : load_data;
                        if (cap_write && !access_err) begin
                            mem[idx] <= store_data;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
